gate_bist: RTL and testbench

Built-in self-test sequencer for the three-input complex gates in the gate library (AOI21 and its siblings). It drives the three gate inputs of a device under test through all eight input vectors and samples the gate's output after a programmable settle time. Each sample is compared against the selected reference function. Pass/fail, mismatch count and the first failing vector are reported through a start/done handshake. The block sits beside a combinational gate instance in the bench or top level: its outputs feed the gate's inputs and the gate's output returns on `dut_y`.

---
 rtl/gate_bist.sv | 115 +++++++++++
 tb/tb_gate_bist.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_bist.sv
// rtl/gate_bist.sv - self-test sequencer sweeping the eight input vectors of a three-input complex gate
// Compares the gate output against a selectable reference after a programmable settle time.
module gate_bist #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] func_sel,
  input  logic       dut_y,
  output logic       dut_a,
  output logic       dut_b,
  output logic       dut_c,
  output logic       exp_y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_count,
  output logic [2:0] first_fail_vec,
  output logic       first_fail_valid
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES);

  state_t     state;
  logic [2:0] vec;
  logic [3:0] settle_cnt;
  logic [1:0] func_q;
  logic       mismatch;

  always_comb begin
    exp_y = 1'b0;
    case (func_q)
      2'd0:    exp_y = ~((vec[2] & vec[1]) | vec[0]);
      2'd1:    exp_y = ~((vec[2] | vec[1]) & vec[0]);
      2'd2:    exp_y = (vec[2] & vec[1]) | vec[0];
      default: exp_y = (vec[2] | vec[1]) & vec[0];
    endcase
  end

  assign mismatch = (dut_y != exp_y);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= ST_IDLE;
      vec              <= 3'd0;
      settle_cnt       <= 4'd0;
      func_q           <= 2'd0;
      dut_a            <= 1'b0;
      dut_b            <= 1'b0;
      dut_c            <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      fail_count       <= 4'd0;
      first_fail_vec   <= 3'd0;
      first_fail_valid <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state            <= ST_RUN;
            vec              <= 3'd0;
            settle_cnt       <= 4'd0;
            func_q           <= func_sel;
            {dut_a, dut_b, dut_c} <= 3'd0;
            busy             <= 1'b1;
            pass             <= 1'b0;
            fail_count       <= 4'd0;
            first_fail_vec   <= 3'd0;
            first_fail_valid <= 1'b0;
          end
        end

        ST_RUN: begin
          if (settle_cnt == SETTLE_LAST) begin
            settle_cnt <= 4'd0;
            if (mismatch) begin
              fail_count <= fail_count + 4'd1;
              if (!first_fail_valid) begin
                first_fail_vec   <= vec;
                first_fail_valid <= 1'b1;
              end
            end
            if (vec == 3'd7) begin
              // The vector-7 mismatch has not reached fail_count yet, so fold it in here.
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (fail_count == 4'd0) && !mismatch;
              {dut_a, dut_b, dut_c} <= 3'd0;
            end else begin
              vec <= vec + 3'd1;
              {dut_a, dut_b, dut_c} <= vec + 3'd1;
            end
          end else begin
            settle_cnt <= settle_cnt + 4'd1;
          end
        end

        ST_DONE: state <= ST_IDLE;

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_bist.sv
// tb/tb_gate_bist.sv - randomized self-checking bench for gate_bist
// Four instances (settle 0, 1, 2, 15) run each sweep side by side against a vector-level model.
module tb_gate_bist;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [1:0] func_sel;
  logic [3:0] dut_y;
  logic [3:0] dut_a, dut_b, dut_c, exp_y, busy, done, pass, first_fail_valid;
  logic [3:0] fail_count [4];
  logic [2:0] first_fail_vec [4];
  logic [3:0] st1, st2;

  int mode;
  int gate_sel;
  int total;
  int passed;

  genvar g;
  for (g = 0; g < 4; g++) begin : g_dut
    gate_bist #(.SETTLE_CYCLES(g == 0 ? 0 : g == 1 ? 1 : g == 2 ? 2 : 15)) u_dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .start            (start),
      .func_sel         (func_sel),
      .dut_y            (dut_y[g]),
      .dut_a            (dut_a[g]),
      .dut_b            (dut_b[g]),
      .dut_c            (dut_c[g]),
      .exp_y            (exp_y[g]),
      .busy             (busy[g]),
      .done             (done[g]),
      .pass             (pass[g]),
      .fail_count       (fail_count[g]),
      .first_fail_vec   (first_fail_vec[g]),
      .first_fail_valid (first_fail_valid[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int settle_of(input int idx);
    return (idx == 0) ? 0 : (idx == 1) ? 1 : (idx == 2) ? 2 : 15;
  endfunction

  function automatic bit fn(input int sel, input int v);
    bit a, b, c;
    a = v[2];
    b = v[1];
    c = v[0];
    case (sel & 3)
      0:       return !((a && b) || c);
      1:       return !((a || b) && c);
      2:       return (a && b) || c;
      default: return (a || b) && c;
    endcase
  endfunction

  // Gate under test: mode 0 good, 1 stuck-at-0, 2 stuck-at-1, 3 output valid three cycles after inputs change.
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      st1[i] <= fn(gate_sel, {29'd0, dut_a[i], dut_b[i], dut_c[i]});
      st2[i] <= st1[i];
    end
  end

  always_comb begin
    dut_y = '0;
    for (int i = 0; i < 4; i++) begin
      case (mode)
        0:       dut_y[i] = fn(gate_sel, {29'd0, dut_a[i], dut_b[i], dut_c[i]});
        1:       dut_y[i] = 1'b0;
        2:       dut_y[i] = 1'b1;
        default: dut_y[i] = st2[i];
      endcase
    end
  end

  // Expected result of a whole sweep from the vector-level view of the gate.
  task automatic model(input int md, input int gsel, input int fsel, input int s,
                       output int fails, output int first);
    int o, n, j;
    fails = 0;
    first = -1;
    for (int k = 0; k < 8; k++) begin
      case (md)
        0: o = fn(gsel, k);
        1: o = 0;
        2: o = 1;
        default: begin
          n = (k + 1) * (s + 1) - 3;
          j = (n < 0) ? 0 : n / (s + 1);
          o = fn(gsel, j);
        end
      endcase
      if (o != int'(fn(fsel, k))) begin
        fails++;
        if (first < 0) first = k;
      end
    end
  endtask

  task automatic run_sweep(input int md, input int gsel, input int fsel, input bit scramble);
    int done_at [4];
    int done_cnt [4];
    int ef, efirst, s;
    mode = md;
    gate_sel = gsel;
    func_sel = 2'(fsel);
    repeat (4) @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (scramble) func_sel = 2'($urandom);
    total++;
    if (busy !== 4'hf) $display("FAIL busy_rise: got %b expected 1111", busy);
    else passed++;
    for (int i = 0; i < 4; i++) begin
      done_at[i] = -1;
      done_cnt[i] = 0;
    end
    for (int n = 1; n <= 135; n++) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
        if (done[i]) begin
          done_cnt[i]++;
          if (done_at[i] < 0) done_at[i] = n;
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      s = settle_of(i);
      model(md, gsel, fsel, s, ef, efirst);
      total++;
      if (done_at[i] != 8 * (s + 1))
        $display("FAIL done_latency s%0d: got %0d expected %0d", s, done_at[i], 8 * (s + 1));
      else passed++;
      total++;
      if (done_cnt[i] != 1) $display("FAIL done_pulses s%0d: got %0d expected 1", s, done_cnt[i]);
      else passed++;
      total++;
      if (pass[i] !== (ef == 0)) $display("FAIL pass s%0d: got %b expected %0d", s, pass[i], ef == 0);
      else passed++;
      total++;
      if (fail_count[i] !== 4'(ef)) $display("FAIL fail_count s%0d: got %0d expected %0d", s, fail_count[i], ef);
      else passed++;
      total++;
      if (first_fail_valid[i] !== (efirst >= 0))
        $display("FAIL first_fail_valid s%0d: got %b expected %0d", s, first_fail_valid[i], efirst >= 0);
      else passed++;
      total++;
      if (first_fail_vec[i] !== 3'((efirst < 0) ? 0 : efirst))
        $display("FAIL first_fail_vec s%0d: got %0d expected %0d", s, first_fail_vec[i], (efirst < 0) ? 0 : efirst);
      else passed++;
    end
    total++;
    if (busy !== 4'h0) $display("FAIL busy_fall: got %b expected 0000", busy);
    else passed++;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b0;
    func_sel = 2'd0;
    mode = 0;
    gate_sel = 0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({dut_a, dut_b, dut_c, busy, done, pass, first_fail_valid} !== 28'd0)
      $display("FAIL reset_flags: got %h expected 0", {dut_a, dut_b, dut_c, busy, done, pass, first_fail_valid});
    else passed++;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (fail_count[i] !== 4'd0 || first_fail_vec[i] !== 3'd0)
        $display("FAIL reset_counts s%0d: got %0d/%0d expected 0/0", settle_of(i), fail_count[i], first_fail_vec[i]);
      else passed++;
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_good_gates;
    for (int f = 0; f < 4; f++) run_sweep(0, f, f, 1'b0);
  endtask

  task automatic test_stuck;
    run_sweep(1, 0, 0, 1'b0);
    run_sweep(2, 0, 0, 1'b0);
  endtask

  task automatic test_wrong_function;
    run_sweep(0, 0, 1, 1'b1);
  endtask

  task automatic test_slow_gate;
    run_sweep(3, 0, 0, 1'b0);
    run_sweep(3, 2, 2, 1'b1);
  endtask

  task automatic test_random;
    for (int r = 0; r < 6; r++)
      run_sweep(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b1);
  endtask

  task automatic test_back_to_back;
    int pulses, width, widest, budget;
    mode = 0;
    gate_sel = int'($urandom_range(0, 3));
    func_sel = 2'(gate_sel);
    @(negedge clk);
    start = 1'b1;
    pulses = 0;
    width = 0;
    widest = 0;
    for (int n = 0; n < 60; n++) begin
      @(posedge clk);
      #1;
      if (done[2]) begin
        if (width == 0) pulses++;
        width++;
        if (width > widest) widest = width;
      end else begin
        width = 0;
      end
    end
    start = 1'b0;
    total++;
    if (pulses != 2) $display("FAIL b2b_sweeps: got %0d expected 2", pulses);
    else passed++;
    total++;
    if (widest != 1) $display("FAIL b2b_done_width: got %0d expected 1", widest);
    else passed++;
    budget = 0;
    while (busy !== 4'h0 && budget < 200) begin
      @(posedge clk);
      #1;
      budget++;
    end
    total++;
    if (busy !== 4'h0) $display("FAIL b2b_drain: got busy %b expected 0000", busy);
    else passed++;
    total++;
    if (pass[2] !== 1'b1) $display("FAIL b2b_pass: got %b expected 1", pass[2]);
    else passed++;
  endtask

  task automatic test_reset_midsweep;
    int stray;
    mode = 1;
    gate_sel = 0;
    func_sel = 2'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (13) @(posedge clk);
    #2;
    total++;
    if ({dut_a[2], dut_b[2], dut_c[2]} !== 3'b100 || fail_count[2] !== 4'd2)
      $display("FAIL pre_reset_state: got vec %b count %0d expected 100 2", {dut_a[2], dut_b[2], dut_c[2]}, fail_count[2]);
    else passed++;
    rst_n = 1'b0;
    #1;
    total++;
    if ({dut_a, dut_b, dut_c, busy, done, pass, first_fail_valid} !== 28'd0)
      $display("FAIL async_reset_flags: got %h expected 0", {dut_a, dut_b, dut_c, busy, done, pass, first_fail_valid});
    else passed++;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (fail_count[i] !== 4'd0 || first_fail_vec[i] !== 3'd0)
        $display("FAIL async_reset_counts s%0d: got %0d/%0d expected 0/0", settle_of(i), fail_count[i], first_fail_vec[i]);
      else passed++;
    end
    stray = 0;
    for (int n = 0; n < 3; n++) begin
      @(posedge clk);
      #1;
      if (done !== 4'h0) stray++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 3; n++) begin
      @(posedge clk);
      #1;
      if (done !== 4'h0 || busy !== 4'h0) stray++;
    end
    total++;
    if (stray != 0) $display("FAIL reset_no_done: got %0d stray cycles expected 0", stray);
    else passed++;
    run_sweep(0, 0, 0, 1'b0);
  endtask

  initial begin
    total = 0;
    passed = 0;
    test_reset;
    test_good_gates;
    test_stuck;
    test_wrong_function;
    test_slow_gate;
    test_back_to_back;
    test_reset_midsweep;
    test_random;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
